// File: rtl/control_unit_pkg.sv
// Control unit shared types: FSM states, op field codes,
// memory direction constants and the control word bundle.
package control_unit_pkg;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_F3, S_DEC,
    S_A0, S_A1, S_A2, S_A3,
    S_L0, S_L1, S_L2, S_L3,
    S_S0, S_S1, S_S2,
    S_I0, S_I1, S_O0,
    S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_IN    = 4'b1010;
  localparam logic [3:0] OP_OUT   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1100;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic [2:0] op_code;
    logic       alu_in1;
    logic       alu_in2;
    logic       alu_outlach;
    logic       alu_out_en;
    logic [3:0] g_in;
    logic [3:0] g_out;
    logic       pc_en;
    logic       pc_inc;
    logic       p0_in;
    logic       p0_out;
    logic       p1_in;
    logic       p1_out;
    logic       mem_en;
    logic       mem_rw;
    logic       mar_en;
    logic       mdr_en_write;
    logic       mdr_en_read;
    logic       mdr_out;
    logic       halted;
    logic       fault;
  } ctrl_t;

  function automatic logic [3:0] reg_sel(input logic [1:0] r);
    reg_sel = 4'b0001 << r;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit to datapath bundle: instruction bus,
// memory handshake and every datapath control line.
interface control_unit_if;
  logic [15:0] bus_in;
  logic        MFC;
  logic [2:0]  opCode;
  logic        ALUin1;
  logic        ALUin2;
  logic        ALU_outlach;
  logic        ALU_outEN;
  logic [3:0]  g_in;
  logic [3:0]  g_out;
  logic        PC_EN;
  logic        pc_inc;
  logic        P0_in;
  logic        P0_out;
  logic        P1_in;
  logic        P1_out;
  logic        mem_EN;
  logic        mem_RW;
  logic        MAR_EN;
  logic        MDR_EN_write;
  logic        MDR_EN_read;
  logic        MDR_out;
  logic        halted;
  logic        fault;

  modport master (
    input  bus_in, MFC,
    output opCode, ALUin1, ALUin2, ALU_outlach, ALU_outEN,
    output g_in, g_out, PC_EN, pc_inc,
    output P0_in, P0_out, P1_in, P1_out,
    output mem_EN, mem_RW, MAR_EN,
    output MDR_EN_write, MDR_EN_read, MDR_out,
    output halted, fault
  );

  modport slave (
    output bus_in, MFC,
    input  opCode, ALUin1, ALUin2, ALU_outlach, ALU_outEN,
    input  g_in, g_out, PC_EN, pc_inc,
    input  P0_in, P0_out, P1_in, P1_out,
    input  mem_EN, mem_RW, MAR_EN,
    input  MDR_EN_write, MDR_EN_read, MDR_out,
    input  halted, fault
  );
endinterface

// File: rtl/control_unit_mfc_watchdog.sv
// Memory wait watchdog: counts MFC-low cycles in a wait
// state and flags the cycle that exhausts the budget.
module mfc_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // restart on every wait-state entry, count stalled cycles
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = tick && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/control_unit.sv
// Microsequenced control unit: fetch/decode/execute FSM
// with registered control outputs and an MFC watchdog.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MFC_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  control_unit_if.master bus
);
  state_t      state;
  state_t      nxt;
  logic [15:8] ir;
  logic [15:8] ir_nxt;
  logic        armed;
  logic        in_wait;
  logic        stall;
  logic        expire;
  logic [3:0]  rd_sel;
  logic [3:0]  rs_sel;
  ctrl_t       ctl;
  ctrl_t       ctl_nxt;

  assign in_wait = (state == S_F1) || (state == S_L1) ||
                   (state == S_S2);
  assign stall   = in_wait && !bus.MFC;
  assign ir_nxt  = (state == S_F3) ? bus.bus_in[15:8] : ir;
  assign rd_sel  = reg_sel(ir_nxt[11:10]);
  assign rs_sel  = reg_sel(ir_nxt[9:8]);

  mfc_watchdog #(.TIMEOUT(MFC_TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .tick   (stall),
    .expire (expire)
  );

  // next state; first cycle out of reset re-enters F0
  always_comb begin
    nxt = state;
    unique case (state)
      S_F0:  nxt = S_F1;
      S_F1:  nxt = bus.MFC ? S_F2 :
                   (expire ? S_FAULT : S_F1);
      S_F2:  nxt = S_F3;
      S_F3:  nxt = S_DEC;
      S_DEC: begin
        unique case (1'b1)
          !ir[15]:              nxt = S_A0;
          ir[15:12] == OP_LOAD:  nxt = S_L0;
          ir[15:12] == OP_STORE: nxt = S_S0;
          ir[15:12] == OP_IN:    nxt = S_I0;
          ir[15:12] == OP_OUT:   nxt = S_O0;
          ir[15:12] == OP_HALT:  nxt = S_HALT;
          default:               nxt = S_F0;
        endcase
      end
      S_A0:  nxt = S_A1;
      S_A1:  nxt = S_A2;
      S_A2:  nxt = S_A3;
      S_A3:  nxt = S_F0;
      S_L0:  nxt = S_L1;
      S_L1:  nxt = bus.MFC ? S_L2 :
                   (expire ? S_FAULT : S_L1);
      S_L2:  nxt = S_L3;
      S_L3:  nxt = S_F0;
      S_S0:  nxt = S_S1;
      S_S1:  nxt = S_S2;
      S_S2:  nxt = bus.MFC ? S_F0 :
                   (expire ? S_FAULT : S_S2);
      S_I0:  nxt = S_I1;
      S_I1:  nxt = S_F0;
      S_O0:  nxt = S_F0;
      S_HALT:  nxt = S_HALT;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FAULT;
    endcase
    if (!armed) nxt = S_F0;
  end

  // control word of the state being entered
  always_comb begin
    ctl_nxt = '0;
    case (nxt)
      S_F0: begin
        ctl_nxt.pc_en  = 1'b1;
        ctl_nxt.mar_en = 1'b1;
        ctl_nxt.pc_inc = 1'b1;
      end
      S_F1, S_L1: begin
        ctl_nxt.mem_en = 1'b1;
        ctl_nxt.mem_rw = MEM_READ;
      end
      S_F2, S_L2: ctl_nxt.mdr_en_read = 1'b1;
      S_F3:       ctl_nxt.mdr_out = 1'b1;
      S_A0: begin
        ctl_nxt.g_out   = rd_sel;
        ctl_nxt.alu_in1 = 1'b1;
      end
      S_A1: begin
        ctl_nxt.g_out   = rs_sel;
        ctl_nxt.alu_in2 = 1'b1;
      end
      S_A2: ctl_nxt.alu_outlach = 1'b1;
      S_A3: begin
        ctl_nxt.alu_out_en = 1'b1;
        ctl_nxt.g_in       = rd_sel;
      end
      S_L0, S_S0: begin
        ctl_nxt.g_out  = rs_sel;
        ctl_nxt.mar_en = 1'b1;
      end
      S_L3: begin
        ctl_nxt.mdr_out = 1'b1;
        ctl_nxt.g_in    = rd_sel;
      end
      S_S1: begin
        ctl_nxt.g_out        = rd_sel;
        ctl_nxt.mdr_en_write = 1'b1;
      end
      S_S2: begin
        ctl_nxt.mem_en = 1'b1;
        ctl_nxt.mem_rw = MEM_WRITE;
      end
      S_I0: ctl_nxt.p1_in = 1'b1;
      S_I1: begin
        ctl_nxt.p1_out = 1'b1;
        ctl_nxt.g_in   = rd_sel;
      end
      S_O0: begin
        ctl_nxt.g_out = rd_sel;
        ctl_nxt.p0_in = 1'b1;
      end
      S_HALT: ctl_nxt.halted = 1'b1;
      S_FAULT: begin
        ctl_nxt.halted = 1'b1;
        ctl_nxt.fault  = 1'b1;
      end
      default: ctl_nxt = '0;
    endcase
    if (!ir_nxt[15] && (nxt inside
        {S_DEC, S_A0, S_A1, S_A2, S_A3})) begin
      ctl_nxt.op_code = ir_nxt[14:12];
    end
  end

  // state, instruction register and registered controls
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_F0;
      ir    <= '0;
      ctl   <= '0;
      armed <= 1'b0;
    end else begin
      state <= nxt;
      ir    <= ir_nxt;
      ctl   <= ctl_nxt;
      armed <= 1'b1;
    end
  end

  assign bus.opCode       = ctl.op_code;
  assign bus.ALUin1       = ctl.alu_in1;
  assign bus.ALUin2       = ctl.alu_in2;
  assign bus.ALU_outlach  = ctl.alu_outlach;
  assign bus.ALU_outEN    = ctl.alu_out_en;
  assign bus.g_in         = ctl.g_in;
  assign bus.g_out        = ctl.g_out;
  assign bus.PC_EN        = ctl.pc_en;
  assign bus.pc_inc       = ctl.pc_inc;
  assign bus.P0_in        = ctl.p0_in;
  assign bus.P0_out       = ctl.p0_out;
  assign bus.P1_in        = ctl.p1_in;
  assign bus.P1_out       = ctl.p1_out;
  assign bus.mem_EN       = ctl.mem_en;
  assign bus.mem_RW       = ctl.mem_rw;
  assign bus.MAR_EN       = ctl.mar_en;
  assign bus.MDR_EN_write = ctl.mdr_en_write;
  assign bus.MDR_EN_read  = ctl.mdr_en_read;
  assign bus.MDR_out      = ctl.mdr_out;
  assign bus.halted       = ctl.halted;
  assign bus.fault        = ctl.fault;
endmodule

// File: tb/tb_control_unit.sv
// Control unit bench: per-cycle expected control words
// from a state-list model, plus F0-to-F0 latency table.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] opc;
    logic       a1, a2, alat, aen;
    logic [3:0] gi, go;
    logic       pce, pci, p0i, p0o, p1i, p1o;
    logic       men, mrw, mar, mdw, mdr, mdo;
    logic       hlt, flt;
  } exp_t;

  typedef struct {
    exp_t        exp;
    string       tag;
    logic        mfc;
    logic [15:0] bus;
    logic        rst;
  } rec_t;

  typedef struct {
    logic [15:0] w;
    int          fl;
    int          dl;
    int          gap;
  } vec_t;

  localparam int NV = 12;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;
  int   cyc;
  bit   recording;
  rec_t sb[$];
  int   stamps[$];
  vec_t tbl [NV];

  control_unit_if cu ();

  control_unit #(.MFC_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t a;
    a.opc  = cu.opCode;
    a.a1   = cu.ALUin1;
    a.a2   = cu.ALUin2;
    a.alat = cu.ALU_outlach;
    a.aen  = cu.ALU_outEN;
    a.gi   = cu.g_in;
    a.go   = cu.g_out;
    a.pce  = cu.PC_EN;
    a.pci  = cu.pc_inc;
    a.p0i  = cu.P0_in;
    a.p0o  = cu.P0_out;
    a.p1i  = cu.P1_in;
    a.p1o  = cu.P1_out;
    a.men  = cu.mem_EN;
    a.mrw  = cu.mem_RW;
    a.mar  = cu.MAR_EN;
    a.mdw  = cu.MDR_EN_write;
    a.mdr  = cu.MDR_EN_read;
    a.mdo  = cu.MDR_out;
    a.hlt  = cu.halted;
    a.flt  = cu.fault;
    return a;
  endfunction

  task automatic push(exp_t e, string tag,
                      logic mfc = 1'b0,
                      logic [15:0] b = 16'hFFFF,
                      logic r = 1'b1);
    rec_t x;
    x.exp = e;
    x.tag = tag;
    x.mfc = mfc;
    x.bus = b;
    x.rst = r;
    sb.push_back(x);
  endtask

  task automatic push_fetch(logic [15:0] w, int lat);
    exp_t e;
    e = '0; e.pce = 1; e.mar = 1; e.pci = 1;
    push(e, "F0");
    for (int k = 0; k <= lat; k++) begin
      e = '0; e.men = 1;
      push(e, "F1", k == lat);
    end
    e = '0; e.mdr = 1;
    push(e, "F2");
    e = '0; e.mdo = 1;
    push(e, "F3", 1'b0, w);
    e = '0;
    if (!w[15]) e.opc = w[14:12];
    push(e, "DEC");
  endtask

  task automatic push_body(logic [15:0] w, int dl);
    exp_t e;
    logic [3:0] d;
    logic [3:0] s;
    d = 4'b0001 << w[11:10];
    s = 4'b0001 << w[9:8];
    if (!w[15]) begin
      e = '0; e.opc = w[14:12]; e.go = d; e.a1 = 1;
      push(e, "A0");
      e = '0; e.opc = w[14:12]; e.go = s; e.a2 = 1;
      push(e, "A1");
      e = '0; e.opc = w[14:12]; e.alat = 1;
      push(e, "A2");
      e = '0; e.opc = w[14:12]; e.aen = 1; e.gi = d;
      push(e, "A3");
    end else if (w[15:12] == 4'h8) begin
      e = '0; e.go = s; e.mar = 1;
      push(e, "L0");
      for (int k = 0; k <= dl; k++) begin
        e = '0; e.men = 1;
        push(e, "L1", k == dl);
      end
      e = '0; e.mdr = 1;
      push(e, "L2");
      e = '0; e.mdo = 1; e.gi = d;
      push(e, "L3");
    end else if (w[15:12] == 4'h9) begin
      e = '0; e.go = s; e.mar = 1;
      push(e, "S0");
      e = '0; e.go = d; e.mdw = 1;
      push(e, "S1");
      for (int k = 0; k <= dl; k++) begin
        e = '0; e.men = 1; e.mrw = 1;
        push(e, "S2", k == dl);
      end
    end else if (w[15:12] == 4'hA) begin
      e = '0; e.p1i = 1;
      push(e, "I0");
      e = '0; e.p1o = 1; e.gi = d;
      push(e, "I1");
    end else if (w[15:12] == 4'hB) begin
      e = '0; e.go = d; e.p0i = 1;
      push(e, "O0");
    end
  endtask

  task automatic run();
    rec_t r;
    exp_t a;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      @(posedge clk);
      #1;
      cyc++;
      a = sample();
      nvec++;
      if (a !== r.exp) begin
        nmis++;
        $display("FAIL %s @%0d: got %h want %h",
                 r.tag, cyc, a, r.exp);
      end
      if (recording && cu.PC_EN === 1'b1)
        stamps.push_back(cyc);
      cu.MFC    = r.mfc;
      cu.bus_in = r.bus;
      rst       = r.rst;
    end
  endtask

  // single bus driver in every cycle
  always @(negedge clk) begin
    int nd;
    nd = int'(cu.ALU_outEN) + $countones(cu.g_out) +
         int'(cu.PC_EN) + int'(cu.P0_out) +
         int'(cu.P1_out) + int'(cu.MDR_out);
    assert (nd <= 1) else begin
      nmis++;
      $display("FAIL bus_excl @%0d: got %0d want <=1",
               cyc, nd);
    end
  end

  initial begin
    exp_t z;
    exp_t h;
    exp_t f;
    nvec = 0;
    nmis = 0;
    cyc = 0;
    recording = 1'b0;
    rst = 1'b0;
    cu.MFC = 1'b0;
    cu.bus_in = 16'hFFFF;
    z = '0;
    h = '0; h.hlt = 1;
    f = '0; f.hlt = 1; f.flt = 1;

    tbl = '{
      '{16'h0100, 0, 0, 9},
      '{16'h3B00, 1, 0, 10},
      '{16'h7500, 0, 0, 9},
      '{16'h12FF, 2, 0, 11},
      '{16'h8600, 0, 3, 12},
      '{16'h8500, 1, 0, 10},
      '{16'h9300, 0, 0, 8},
      '{16'h9300, 2, 1, 11},
      '{16'hA800, 0, 0, 7},
      '{16'hB400, 0, 0, 6},
      '{16'hD000, 0, 0, 5},
      '{16'hF000, 1, 0, 6}
    };

    push(z, "rst", 1'b0, 16'hFFFF, 1'b0);
    push(z, "rst", 1'b0, 16'hFFFF, 1'b1);
    run();

    recording = 1'b1;
    for (int i = 0; i < NV; i++) begin
      push_fetch(tbl[i].w, tbl[i].fl);
      push_body(tbl[i].w, tbl[i].dl);
    end
    push_fetch(16'hC000, 0);
    push(h, "HALT", 1'b1);
    push(h, "HALT", 1'b1);
    push(h, "HALT", 1'b1);
    push(h, "HALT", 1'b1, 16'hFFFF, 1'b0);
    run();
    recording = 1'b0;

    if (stamps.size() != NV + 1) begin
      nvec++;
      nmis++;
      $display("FAIL f0_count: got %0d want %0d",
               stamps.size(), NV + 1);
    end else begin
      for (int i = 0; i < NV; i++) begin
        nvec++;
        if (stamps[i+1] - stamps[i] != tbl[i].gap) begin
          nmis++;
          $display("FAIL gap %h: got %0d want %0d",
                   tbl[i].w, stamps[i+1] - stamps[i],
                   tbl[i].gap);
        end
      end
    end

    push(z, "rst", 1'b0, 16'hFFFF, 1'b1);
    begin
      exp_t e;
      e = '0; e.pce = 1; e.mar = 1; e.pci = 1;
      push(e, "F0");
      for (int k = 0; k < 16; k++) begin
        e = '0; e.men = 1;
        push(e, "F1w");
      end
    end
    push(f, "FAULT", 1'b1);
    push(f, "FAULT", 1'b1);
    push(f, "FAULT", 1'b1, 16'hFFFF, 1'b0);
    push(z, "rst", 1'b0, 16'hFFFF, 1'b1);
    run();

    push_fetch(16'h8600, 0);
    begin
      exp_t e;
      e = '0; e.go = 4'b0100; e.mar = 1;
      push(e, "L0");
      e = '0; e.men = 1;
      push(e, "L1", 1'b0, 16'hFFFF, 1'b0);
      push(z, "abort", 1'b1, 16'hFFFF, 1'b1);
      e = '0; e.pce = 1; e.mar = 1; e.pci = 1;
      push(e, "F0");
      e = '0; e.men = 1;
      push(e, "F1", 1'b1);
    end
    run();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
